icache_direct: RTL
==================

Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the CPU instruction port (ibus) and one input of the cbus arbiter.
- Hits return data in the same cycle. A miss issues one cbus read burst that refills a whole line, then retries as a hit.
- The block never writes to memory. Every instruction address is treated as cacheable.

Parameters:
- OFFSET_BITS, 4, log2 of line size in bytes (16 B line = 4 words).
- INDEX_BITS, 4, log2 of the number of sets (16 lines).
- Derived, not overridable: WORDS_PER_LINE = 2**(OFFSET_BITS-2); TAG_BITS = 32-INDEX_BITS-OFFSET_BITS.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- resetn  in  1  synchronous, active-low reset.
- ireq  in  ibus_req_t  CPU fetch request: valid, addr[31:0].
- iresp  out  ibus_resp_t  addr_ok, data_ok, data[31:0].
- creq  out  cbus_req_t  valid, is_write, size, addr, strobe, data, len (to the arbiter).
- cresp  in  cbus_resp_t  okay, last, data[31:0] (from the arbiter).

Behaviour:
- Reset (resetn=0 at a clock edge):
  - all line valid bits cleared; state=IDLE; refill word counter=0.
  - iresp and creq are all-zero in the reset cycle and the cycle after.
- Address split: offset=addr[OFFSET_BITS-1:0]; index=next INDEX_BITS bits; tag=remaining upper bits. addr[1:0] is ignored (word fetch).
- State IDLE:
  - Hit (ireq.valid, valid[index], tag match): addr_ok=1, data_ok=1, data=word addr[OFFSET_BITS-1:2] of the line, all combinationally in the same cycle. Stay IDLE.
  - Miss: addr_ok=data_ok=0. Latch the line-aligned address. Next cycle → FETCH.
- State FETCH:
  - creq.valid=1; is_write=0; size=4 bytes; addr=latched line base; len=WORDS_PER_LINE beats; strobe=0; data=0.
  - creq stays constant for the whole burst; the arbiter samples it only after granting.
  - Each cycle with cresp.okay=1: write cresp.data to the line RAM at the counter position, then increment the counter.
  - okay gaps (okay=0) stall the counter; no data is written.
  - Beat with cresp.okay=1 and cresp.last=1: write the final word, set tag[index] and valid[index], clear the counter. Next cycle → IDLE with creq.valid=0.
  - The still-asserted ireq then hits.
- iresp stays all-zero throughout FETCH. ireq is held stable by the CPU until addr_ok; the cache does not re-sample addr during FETCH.
- The line RAM is written only in FETCH. The refilled line overwrites any previous tag at that index (conflict eviction, no replacement policy).
- cresp.last before WORDS_PER_LINE beats is a protocol error. The line is still marked valid; verification flags it with an assertion.
- Reset mid-FETCH:
  - aborts the burst; creq.valid=0 from the cycle after the reset edge.
  - the partially filled line stays invalid because all valid bits clear.
- The arbiter is reset on the same resetn, so no orphan burst remains.
- ireq.valid=0 in IDLE: no response, no state change.

Decomposition:
- Shared package (common.svh): ibus_req_t, ibus_resp_t, cbus_req_t, cbus_resp_t, and the size/len encodings (MSIZE4, MLEN4).
- Block-local package or localparams: icache_state_t {IDLE, FETCH}; derived width constants.
- One natural sub-module: icache_line_ram, a single-write, async-read word array of depth 2**INDEX_BITS*WORDS_PER_LINE.
- Tag and valid arrays stay in the top block as flops.

Test Plan:
- Cold miss: reset, then ireq addr=0xBFC00000.
  - Required: creq.valid next cycle, addr=0xBFC00000, len=4 beats, is_write=0.
  - Feed beats 0x11,0x22,0x33,0x44 (last on the fourth).
  - One cycle after last: addr_ok=data_ok=1, data=0x11.
- Hit in same line: ireq addr=0xBFC00008 after the cold fill → same-cycle data_ok=1, data=0x33; creq.valid stays 0.
- Unaligned-in-line miss: ireq addr=0x8000000C → creq.addr=0x80000000; beats A0..A3 → response data=A3.
- Conflict eviction:
  - fill 0xBFC00000, then request 0xBFC00100 (same index 0) → new burst at 0xBFC00100; hit data comes from the new line.
  - Re-request 0xBFC00000 → miss again.
- okay gaps: insert okay=0 cycles between beats 1 and 2 → counter holds; the final line content is still in beat order; data_ok only after last.
- Reset mid-refill:
  - assert resetn=0 after 2 of 4 beats → creq.valid=0 the following cycle.
  - After release, the same address misses and re-issues the full 4-beat burst.

Source files
------------

// File: rtl/icache_direct_pkg.sv
// Shared types for the direct-mapped instruction cache.
//   ibus_req_t / ibus_resp_t : CPU fetch port (valid+addr in, addr_ok/data_ok/data out)
//   cbus_req_t / cbus_resp_t : memory-side burst port toward the arbiter
//   MSIZE4 / MLEN4           : size is log2(bytes per beat), len is beats minus one
//   icache_state_t           : refill FSM states
package icache_direct_pkg;

  typedef struct packed {
    logic        valid;
    logic [31:0] addr;
  } ibus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] data;
  } ibus_resp_t;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [2:0]  size;
    logic [31:0] addr;
    logic [3:0]  strobe;
    logic [31:0] data;
    logic [3:0]  len;
  } cbus_req_t;

  typedef struct packed {
    logic        okay;
    logic        last;
    logic [31:0] data;
  } cbus_resp_t;

  localparam logic [2:0] MSIZE4 = 3'd2;
  localparam logic [3:0] MLEN4  = 4'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } icache_state_t;

  // cbus len field for a burst of 'words' beats
  function automatic logic [3:0] burst_len(input int words);
    return 4'(words - 1);
  endfunction

endpackage

// File: rtl/icache_line_ram.sv
// Word array holding all cache line data.
//   clk   : clock
//   we    : write enable (one word per cycle)
//   waddr : write word address {index, word}
//   wdata : write data
//   raddr : asynchronous read word address {index, word}
//   rdata : asynchronous read data
module icache_line_ram #(
  parameter int ADDR_BITS = 6
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] waddr,
  input  logic [31:0]          wdata,
  input  logic [ADDR_BITS-1:0] raddr,
  output logic [31:0]          rdata
);

  logic [31:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache.
//   clk    : clock
//   resetn : synchronous active-low reset
//   ireq   : CPU fetch request (valid, addr)
//   iresp  : CPU fetch response (addr_ok, data_ok, data); hits answer in the same cycle
//   creq   : line refill burst request toward the arbiter
//   cresp  : refill beats (okay, last, data)
//
// state | meaning
// IDLE  | serve hits combinationally; a miss latches the line base and moves to FETCH
// FETCH | one read burst in flight; each okay beat fills the next word, last beat validates the line
module icache_direct
  import icache_direct_pkg::*;
#(
  parameter int OFFSET_BITS = 4,
  parameter int INDEX_BITS  = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  output cbus_req_t  creq,
  input  cbus_resp_t cresp
);

  localparam int WORD_BITS      = OFFSET_BITS - 2;
  localparam int WORDS_PER_LINE = 2**WORD_BITS;
  localparam int TAG_BITS       = 32 - INDEX_BITS - OFFSET_BITS;
  localparam int SETS           = 2**INDEX_BITS;
  localparam int LINE_BITS      = TAG_BITS + INDEX_BITS;
  localparam int RAM_BITS       = INDEX_BITS + WORD_BITS;

  icache_state_t         state;
  logic [SETS-1:0]       valid_q;
  logic [TAG_BITS-1:0]   tag_q [SETS];
  logic [LINE_BITS-1:0]  line_q;
  logic [WORD_BITS-1:0]  cnt_q;

  logic [TAG_BITS-1:0]   req_tag;
  logic [INDEX_BITS-1:0] req_index;
  logic [WORD_BITS-1:0]  req_word;
  logic [TAG_BITS-1:0]   line_tag;
  logic [INDEX_BITS-1:0] line_index;
  logic                  hit;
  logic                  fill_we;
  logic                  fill_done;
  logic [31:0]           ram_rdata;
  logic                  unused_addr_lsb;

  assign req_tag    = ireq.addr[31 -: TAG_BITS];
  assign req_index  = ireq.addr[OFFSET_BITS +: INDEX_BITS];
  assign req_word   = ireq.addr[OFFSET_BITS-1:2];
  assign line_tag   = line_q[LINE_BITS-1:INDEX_BITS];
  assign line_index = line_q[INDEX_BITS-1:0];

  // Word fetches only; byte offset within the word carries no information.
  assign unused_addr_lsb = ^ireq.addr[1:0];

  assign hit = (state == IDLE) && ireq.valid && valid_q[req_index] &&
               (tag_q[req_index] == req_tag);

  assign fill_we   = (state == FETCH) && cresp.okay;
  assign fill_done = fill_we && cresp.last;

  icache_line_ram #(
    .ADDR_BITS(RAM_BITS)
  ) u_line_ram (
    .clk  (clk),
    .we   (fill_we),
    .waddr({line_index, cnt_q}),
    .wdata(cresp.data),
    .raddr({req_index, req_word}),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      line_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ireq.valid && !hit) begin
            line_q <= ireq.addr[31:OFFSET_BITS];
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (cresp.okay) begin
            if (cresp.last) begin
              valid_q[line_index] <= 1'b1;
              cnt_q               <= '0;
              state               <= IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tags need no reset: valid_q guards every use.
  always_ff @(posedge clk) begin
    if (fill_done) tag_q[line_index] <= line_tag;
  end

  // Outputs are forced quiet while resetn is low so the reset cycle itself is clean.
  always_comb begin
    iresp = '0;
    creq  = '0;
    if (resetn) begin
      if (hit) begin
        iresp.addr_ok = 1'b1;
        iresp.data_ok = 1'b1;
        iresp.data    = ram_rdata;
      end
      if (state == FETCH) begin
        creq.valid    = 1'b1;
        creq.is_write = 1'b0;
        creq.size     = MSIZE4;
        creq.addr     = {line_q, {OFFSET_BITS{1'b0}}};
        creq.len      = burst_len(WORDS_PER_LINE);
      end
    end
  end

  // A last beat must coincide with the final word of the line.
  a_full_burst: assert property (@(posedge clk) disable iff (!resetn)
    fill_done |-> (cnt_q == WORD_BITS'(WORDS_PER_LINE - 1)));

endmodule
